// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle between decode and execute for the registered immediate generator.
// The slave modport is the generator's view and the master modport is the driver/consumer view.
interface imm_gen_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_inst, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal
  );

  modport master (
    output in_valid, in_inst, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator with valid/ready handshake.
// SKID=1 adds a second register so that in_ready depends only on state.
module imm_gen_pipe #(
  parameter int XLEN = 32,
  parameter int SKID = 1
) (
  input  logic           clk,
  input  logic           rst,
  imm_gen_pipe_if.slave  bus
);
  localparam int PW      = XLEN + 4;
  localparam int SHAMT_W = (XLEN == 64) ? 6 : 5;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_CSR = 3'd6;
  localparam logic [2:0] FMT_ILL = 3'd7;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Payload layout: {illegal, fmt[2:0], imm[XLEN-1:0]}.
  // Every zero-extended form leaves bit 31 clear, so one sign-extension from bit 31 serves all formats.
  function automatic logic [PW-1:0] decode(input logic [31:0] inst);
    logic [31:0]     v32;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    v32 = 32'd0;
    fmt = FMT_ILL;
    if (inst[1:0] != 2'b11) begin
      fmt = FMT_ILL;
    end else begin
      case (inst[6:0])
        OPC_OP_IMM: begin
          fmt = FMT_I;
          if (inst[13:12] == 2'b01) begin
            v32[SHAMT_W-1:0] = inst[20 +: SHAMT_W];
          end else begin
            v32 = {{20{inst[31]}}, inst[31:20]};
          end
        end
        OPC_LOAD, OPC_JALR, OPC_FENCE: begin
          fmt = FMT_I;
          v32 = {{20{inst[31]}}, inst[31:20]};
        end
        OPC_STORE: begin
          fmt = FMT_S;
          v32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        end
        OPC_BRANCH: begin
          fmt = FMT_B;
          v32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        end
        OPC_LUI, OPC_AUIPC: begin
          fmt = FMT_U;
          v32 = {inst[31:12], 12'd0};
        end
        OPC_JAL: begin
          fmt = FMT_J;
          v32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        end
        OPC_SYSTEM: begin
          fmt = FMT_CSR;
          if (inst[14]) begin
            v32 = {27'd0, inst[19:15]};
          end else begin
            v32 = {20'd0, inst[31:20]};
          end
        end
        OPC_OP: begin
          fmt = FMT_R;
        end
        default: begin
          fmt = FMT_ILL;
        end
      endcase
    end
    imm       = {XLEN{v32[31]}};
    imm[31:0] = v32;
    return {(fmt == FMT_ILL), fmt, imm};
  endfunction

  logic [1:0]    state_r;
  logic [1:0]    state_nxt_s;
  logic [PW-1:0] m_r;
  logic [PW-1:0] m_nxt_s;
  logic [PW-1:0] k_r;
  logic [PW-1:0] k_nxt_s;
  logic [PW-1:0] dec_s;
  logic          in_ready_s;
  logic          out_valid_s;
  logic          accept_s;
  logic          pop_s;

  assign dec_s       = decode(bus.in_inst);
  assign out_valid_s = (state_r != ST_EMPTY);
  assign in_ready_s  = (SKID != 0) ? (!rst && (state_r != ST_TWO))
                                   : (!rst && (!out_valid_s || bus.out_ready));
  assign accept_s    = bus.in_valid && in_ready_s;
  assign pop_s       = out_valid_s && bus.out_ready;

  // Next-state and storage update; M is cleared on the way to EMPTY so out_* read 0 when idle.
  always_comb begin
    state_nxt_s = state_r;
    m_nxt_s     = m_r;
    k_nxt_s     = k_r;
    case (state_r)
      ST_EMPTY: begin
        if (accept_s) begin
          m_nxt_s     = dec_s;
          state_nxt_s = ST_ONE;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (accept_s && pop_s) begin
          m_nxt_s = dec_s;
        end else if (accept_s) begin
          k_nxt_s     = dec_s;
          state_nxt_s = ST_TWO;
        end else if (pop_s) begin
          m_nxt_s     = '0;
          state_nxt_s = ST_EMPTY;
        end else begin
          state_nxt_s = ST_ONE;
        end
      end
      ST_TWO: begin
        if (pop_s) begin
          m_nxt_s     = k_r;
          k_nxt_s     = '0;
          state_nxt_s = ST_ONE;
        end else begin
          state_nxt_s = ST_TWO;
        end
      end
      default: begin
        m_nxt_s     = '0;
        k_nxt_s     = '0;
        state_nxt_s = ST_EMPTY;
      end
    endcase
  end

  // State and payload registers, cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_EMPTY;
      m_r     <= '0;
      k_r     <= '0;
    end else begin
      state_r <= state_nxt_s;
      m_r     <= m_nxt_s;
      k_r     <= k_nxt_s;
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = out_valid_s;
  assign bus.out_imm     = m_r[XLEN-1:0];
  assign bus.out_fmt     = m_r[XLEN+2:XLEN];
  assign bus.out_illegal = m_r[XLEN+3];
endmodule
